axi_s_fifo: RTL

- Synchronous AXI-Stream FIFO inserted between the stream master (axi_s_m) and stream slave (axi_s_s).
- Buffers tdata/tlast beats so that the slave can stall without back-pressuring the master beat-by-beat.
- First-word-fall-through; exposes fill level and stored-packet count for debug/flow control.

---
 rtl/axi_s_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/axi_s_fifo.sv
// AXI-Stream FWFT FIFO with fill level and stored-packet count; optional store-and-forward via AXIS_FIFO_PKT_MODE_EN.
// Latency: a beat pushed into an empty FIFO is presented one aclk edge later (no bypass).
// Backpressure: s_tready is registered and drops only when all DEPTH entries are occupied.
module axi_s_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tlast,
    output logic [$clog2(DEPTH):0]  level,
    output logic [$clog2(DEPTH):0]  pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [CW-1:0]       wr_ptr;
    logic [CW-1:0]       rd_ptr;
    logic [CW-1:0]       level_q;
    logic [CW-1:0]       pkt_q;
    logic [CW-1:0]       level_nxt;
    logic [CW-1:0]       pkt_nxt;
    logic                ready_q;
    logic                valid;
    logic                push;
    logic                pop;
    logic [DATA_WIDTH:0] head;
    logic                head_last;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_last = head[DATA_WIDTH];
    assign push      = s_tvalid && ready_q;
    assign pop       = valid && m_tready;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop)
            level_nxt = level_q + ONE;
        else if (!push && pop)
            level_nxt = level_q - ONE;
    end

    always_comb begin
        pkt_nxt = pkt_q;
        case ({push && s_tlast, pop && head_last})
            2'b10:   pkt_nxt = pkt_q + ONE;
            2'b01:   pkt_nxt = pkt_q - ONE;
            default: pkt_nxt = pkt_q;
        endcase
    end

    // Storage carries no reset; stale entries are never presented because m_tdata is gated by m_tvalid.
    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            pkt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ONE;
            if (pop)
                rd_ptr <= rd_ptr + ONE;
            level_q <= level_nxt;
            pkt_q   <= pkt_nxt;
            ready_q <= (level_nxt != FULL);
        end
    end

`ifdef AXIS_FIFO_PKT_MODE_EN
    logic forced_release;
    logic in_pkt;

    // forced_release breaks the deadlock of a full FIFO holding no packet end;
    // in_pkt keeps a packet flowing once its first beat has left.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            forced_release <= 1'b0;
            in_pkt         <= 1'b0;
        end else begin
            if (pop && head_last)
                forced_release <= 1'b0;
            else if (level_q == FULL && pkt_q == '0)
                forced_release <= 1'b1;
            if (pop)
                in_pkt <= !head_last;
        end
    end

    assign valid = (level_q != '0) && ((pkt_q != '0) || forced_release || in_pkt);
`else
    assign valid = (level_q != '0);
`endif

    assign s_tready = ready_q;
    assign m_tvalid = valid;
    assign m_tdata  = valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_tlast  = valid && head_last;
    assign level    = level_q;
    assign pkt_cnt  = pkt_q;

endmodule
